tt_um_hoene_protocol_transmitter: RTL and testbench



---
 rtl/tt_um_hoene_protocol_pkg.sv | 29 ++
 rtl/tt_um_hoene_halfbit_timer.sv | 28 ++
 rtl/tt_um_hoene_protocol_transmitter.sv | 127 ++++++++++++
 tb/tb_tt_um_hoene_protocol_transmitter.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/tt_um_hoene_protocol_pkg.sv
// rtl/tt_um_hoene_protocol_pkg.sv - shared constants, state enum and frame helpers for the LED serial protocol
package tt_um_hoene_protocol_pkg;

  localparam int FRAME_BITS       = 32;
  localparam int PAYLOAD_BITS     = 31;
  localparam int SYNC_HI_HALFBITS = 3;
  localparam int SYNC_LO_HALFBITS = 3;

  // 1 means a '1' bit is sent as low then high; the decoder uses the same constant.
  localparam logic MANCHESTER_POLARITY = 1'b1;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_SYNC_HI,
    TX_SYNC_LO,
    TX_BIT_A,
    TX_BIT_B,
    TX_GAP
  } tx_state_e;

  function automatic logic [FRAME_BITS-1:0] build_frame(input logic [PAYLOAD_BITS-1:0] payload);
    return {payload, ^payload};
  endfunction

  function automatic logic first_half(input logic bit_val);
    return MANCHESTER_POLARITY ? ~bit_val : bit_val;
  endfunction

endpackage

// File: rtl/tt_um_hoene_halfbit_timer.sv
// rtl/tt_um_hoene_halfbit_timer.sv - free-running half-bit timer, tick on terminal count
module tt_um_hoene_halfbit_timer #(
  parameter int HALF_BIT_CYCLES = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int CW = (HALF_BIT_CYCLES > 2) ? $clog2(HALF_BIT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(HALF_BIT_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clear || tick) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/tt_um_hoene_protocol_transmitter.sv
// rtl/tt_um_hoene_protocol_transmitter.sv - sync violation + 32 Manchester bits + idle gap frame transmitter
module tt_um_hoene_protocol_transmitter
  import tt_um_hoene_protocol_pkg::*;
#(
  parameter int HALF_BIT_CYCLES = 8,
  parameter int GAP_HALFBITS    = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [PAYLOAD_BITS-1:0] tx_data,
  input  logic                    tx_valid,
  output logic                    tx_ready,
  output logic                    tx_out,
  output logic                    tx_busy,
  output logic                    tx_done
);

  localparam logic [3:0] SYNC_HI_LAST = 4'(SYNC_HI_HALFBITS - 1);
  localparam logic [3:0] SYNC_LO_LAST = 4'(SYNC_LO_HALFBITS - 1);
  localparam logic [3:0] GAP_LAST     = 4'(GAP_HALFBITS - 1);

  tx_state_e             state_q;
  logic [FRAME_BITS-1:0] shift_q;
  logic [4:0]            bit_cnt_q;
  logic [3:0]            hb_cnt_q;
  logic                  tx_out_q;
  logic                  tick;
  logic                  accept;

  assign tx_ready = (state_q == TX_IDLE);
  assign tx_busy  = (state_q != TX_IDLE);
  assign accept   = tx_valid && tx_ready;
  assign tx_out   = tx_out_q;
  // Decoded from registered state and timer count, so it lines up with the last gap cycle.
  assign tx_done  = (state_q == TX_GAP) && tick && (hb_cnt_q == GAP_LAST);

  tt_um_hoene_halfbit_timer #(
    .HALF_BIT_CYCLES(HALF_BIT_CYCLES)
  ) u_timer (
    .clk  (clk),
    .rst  (rst),
    .clear(accept),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= TX_IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      hb_cnt_q  <= '0;
      tx_out_q  <= 1'b0;
    end else begin
      case (state_q)
        TX_IDLE: begin
          tx_out_q <= 1'b0;
          if (accept) begin
            shift_q   <= build_frame(tx_data);
            bit_cnt_q <= '0;
            hb_cnt_q  <= '0;
            tx_out_q  <= 1'b1;
            state_q   <= TX_SYNC_HI;
          end
        end
        TX_SYNC_HI: begin
          if (tick) begin
            if (hb_cnt_q == SYNC_HI_LAST) begin
              hb_cnt_q <= '0;
              tx_out_q <= 1'b0;
              state_q  <= TX_SYNC_LO;
            end else begin
              hb_cnt_q <= hb_cnt_q + 4'd1;
            end
          end
        end
        TX_SYNC_LO: begin
          if (tick) begin
            if (hb_cnt_q == SYNC_LO_LAST) begin
              hb_cnt_q <= '0;
              tx_out_q <= first_half(shift_q[FRAME_BITS-1]);
              state_q  <= TX_BIT_A;
            end else begin
              hb_cnt_q <= hb_cnt_q + 4'd1;
            end
          end
        end
        TX_BIT_A: begin
          if (tick) begin
            tx_out_q <= ~first_half(shift_q[FRAME_BITS-1]);
            state_q  <= TX_BIT_B;
          end
        end
        TX_BIT_B: begin
          if (tick) begin
            shift_q   <= {shift_q[FRAME_BITS-2:0], 1'b0};
            bit_cnt_q <= bit_cnt_q + 5'd1;
            if (bit_cnt_q == 5'd31) begin
              hb_cnt_q <= '0;
              tx_out_q <= 1'b0;
              state_q  <= TX_GAP;
            end else begin
              // Next bit is already at shift_q[30] before the shift lands.
              tx_out_q <= first_half(shift_q[FRAME_BITS-2]);
              state_q  <= TX_BIT_A;
            end
          end
        end
        TX_GAP: begin
          tx_out_q <= 1'b0;
          if (tick) begin
            if (hb_cnt_q == GAP_LAST) begin
              hb_cnt_q <= '0;
              state_q  <= TX_IDLE;
            end else begin
              hb_cnt_q <= hb_cnt_q + 4'd1;
            end
          end
        end
        default: begin
          state_q  <= TX_IDLE;
          tx_out_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tt_um_hoene_protocol_transmitter.sv
// tb/tb_tt_um_hoene_protocol_transmitter.sv - directed self-checking bench for the frame transmitter
module tb_tt_um_hoene_protocol_transmitter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [30:0] d1 = '0, d2 = '0;
  logic        v1 = 1'b0, v2 = 1'b0;
  logic        r1, o1, b1, dn1;
  logic        r2, o2, b2, dn2;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  tt_um_hoene_protocol_transmitter #(.HALF_BIT_CYCLES(8), .GAP_HALFBITS(2)) dut1 (
    .clk(clk), .rst(rst), .tx_data(d1), .tx_valid(v1),
    .tx_ready(r1), .tx_out(o1), .tx_busy(b1), .tx_done(dn1)
  );

  tt_um_hoene_protocol_transmitter #(.HALF_BIT_CYCLES(3), .GAP_HALFBITS(1)) dut2 (
    .clk(clk), .rst(rst), .tx_data(d2), .tx_valid(v2),
    .tx_ready(r2), .tx_out(o2), .tx_busy(b2), .tx_done(dn2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic sel_out(input int sel);
    return (sel == 1) ? o1 : o2;
  endfunction
  function automatic logic sel_done(input int sel);
    return (sel == 1) ? dn1 : dn2;
  endfunction
  function automatic logic sel_busy(input int sel);
    return (sel == 1) ? b1 : b2;
  endfunction
  function automatic logic sel_ready(input int sel);
    return (sel == 1) ? r1 : r2;
  endfunction

  // Called at the sample point of the first cycle after acceptance; returns at the idle cycle.
  task automatic check_frame(input int sel, input logic [31:0] f, input int h, input int gap, input string tag);
    int len;
    int bad_out;
    int bad_done;
    int bad_busy;
    len = (70 + gap) * h;
    bad_out = 0;
    bad_done = 0;
    bad_busy = 0;
    for (int c = 0; c < len; c++) begin
      int hb;
      int k;
      logic e;
      hb = c / h;
      if (hb < 3) e = 1'b1;
      else if (hb < 6) e = 1'b0;
      else if (hb < 70) begin
        k = hb - 6;
        e = ((k % 2) == 0) ? ~f[31 - k/2] : f[31 - k/2];
      end else e = 1'b0;
      if (sel_out(sel) !== e) bad_out++;
      if (sel_done(sel) !== (c == len - 1)) bad_done++;
      if (sel_busy(sel) !== 1'b1) bad_busy++;
      step();
    end
    chk({tag, "_line"}, bad_out, 0);
    chk({tag, "_done"}, bad_done, 0);
    chk({tag, "_busy"}, bad_busy, 0);
    chk({tag, "_ready_after"}, sel_ready(sel), 1'b1);
    chk({tag, "_busy_after"}, sel_busy(sel), 1'b0);
  endtask

  task automatic send1(input logic [30:0] d);
    d1 = d;
    v1 = 1'b1;
    step();
    v1 = 1'b0;
  endtask

  initial begin
    int changes;
    int dones;

    rst = 1'b1;
    step(); step(); step();
    chk("reset_out", o1, 1'b0);
    chk("reset_ready", r1, 1'b1);
    chk("reset_busy", b1, 1'b0);
    chk("reset_done", dn1, 1'b0);
    rst = 1'b0;

    changes = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (o1 !== 1'b0 || r1 !== 1'b1 || b1 !== 1'b0 || dn1 !== 1'b0) changes++;
    end
    chk("idle_hold", changes, 0);

    // payload 1 -> frame {1, parity 1}
    send1(31'h0000_0001);
    check_frame(1, 32'h0000_0003, 8, 2, "single_01");

    send1(31'h7FFF_FFFF);
    check_frame(1, 32'hFFFF_FFFF, 8, 2, "parity_ones");

    // 16 ones -> parity 0
    send1(31'h5555_5555);
    check_frame(1, 32'hAAAA_AAAA, 8, 2, "parity_even");

    // 15 ones -> parity 1
    send1(31'h5555_5554);
    check_frame(1, 32'hAAAA_AAA9, 8, 2, "parity_odd");

    // back-to-back with valid held and data changed mid-frame
    d1 = 31'h0123_4567;
    v1 = 1'b1;
    step();
    d1 = 31'h7ABC_DEF0;
    check_frame(1, 32'h0246_8ACE, 8, 2, "b2b_first");
    step();
    chk("b2b_second_accept", b1, 1'b1);
    v1 = 1'b0;
    check_frame(1, 32'hF579_BDE0, 8, 2, "b2b_second");

    // reset during bit 10
    send1(31'h0000_0001);
    for (int i = 0; i < 6*8 + 20*8 + 3; i++) step();
    chk("pre_reset_busy", b1, 1'b1);
    rst = 1'b1;
    step();
    chk("midrst_out", o1, 1'b0);
    chk("midrst_ready", r1, 1'b1);
    chk("midrst_busy", b1, 1'b0);
    rst = 1'b0;
    dones = 0;
    for (int i = 0; i < 600; i++) begin
      if (dn1 !== 1'b0 || o1 !== 1'b0) dones++;
      step();
    end
    chk("midrst_quiet", dones, 0);
    send1(31'h7ABC_DEF0);
    check_frame(1, 32'hF579_BDE0, 8, 2, "after_rst");

    // short half-bit and single gap half-bit on the second instance
    d2 = 31'h7ABC_DEF0;
    v2 = 1'b1;
    step();
    v2 = 1'b0;
    check_frame(2, 32'hF579_BDE0, 3, 1, "h3_frame");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
